// File: rtl/bcd_scan_driver_if.sv
// ---------------------------------------------------------------------------
// bcd_scan_driver_if
// Bundles the load/status/scan signals of bcd_scan_driver.
//   Value    : binary value to convert (sampled on an accepted Load)
//   Load     : convert request, accepted only while Busy is low
//   Busy     : conversion in progress
//   Done     : one-cycle pulse when the display register updates
//   Ovf      : last accepted Value was clamped to 10^DIGITS-1
//   BCD      : BCD digit of the current scan slot (to segment decoder)
//   DigitSel : active-low one-hot digit enable, bit 0 = least significant
// master drives Value/Load, slave is the driver block itself.
// ---------------------------------------------------------------------------
interface bcd_scan_driver_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]  Value;
    logic              Load;
    logic              Busy;
    logic              Done;
    logic              Ovf;
    logic [3:0]        BCD;
    logic [DIGITS-1:0] DigitSel;

    modport master (
        output Value, Load,
        input  Busy, Done, Ovf, BCD, DigitSel
    );

    modport slave (
        input  Value, Load,
        output Busy, Done, Ovf, BCD, DigitSel
    );
endinterface

// File: rtl/bcd_scan_driver.sv
// ---------------------------------------------------------------------------
// bcd_scan_driver
// Converts a binary value to packed BCD with an iterative shift-and-add-3
// (one bit per clock), holds the result in a display register and
// time-multiplexes the digits towards a BCD-to-segment decoder.
//
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : bcd_scan_driver_if.slave (Value, Load, Busy, Done, Ovf, BCD,
//          DigitSel)
//
// Parameters: WIDTH (binary input width), DIGITS (display digits),
//             SCAN_DIV (clocks per scan slot, >= 1).
//
// Build option: LEADING_ZERO_BLANK_EN -- when defined, digits above the most
// significant nonzero digit output 4'hF (decoder blank code); digit 0 is
// never blanked. Port list is the same in both builds.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for Load; display register stable
// ST_CONV | one shift-and-add-3 iteration per clock, cnt_q iterations left
// ---------------------------------------------------------------------------
module bcd_scan_driver #(
    parameter int WIDTH    = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    bcd_scan_driver_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    // Add 3 to every nibble that is 5 or more, so the following shift
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] a);
        logic [BCD_W-1:0] r;
        r = a;
        for (int k = 0; k < DIGITS; k++) begin
            if (a[4*k +: 4] >= 4'd5) r[4*k +: 4] = a[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    typedef enum logic {ST_IDLE, ST_CONV} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [BCD_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCD_W-1:0]    disp_q, disp_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [3:0]          bcd_q, bcd_d;
    logic [DIGITS-1:0]   sel_q, sel_d;

    logic [BCD_W-1:0]       acc_adj;
    logic [BCD_W+WIDTH-1:0] pair_sh;
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]      blank;
    logic                   lead_zero;
`endif

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        pre_d   = pre_q;
        idx_d   = idx_q;
        bcd_d   = 4'd0;
        sel_d   = '1;

        acc_adj = add3(acc_q);
        pair_sh = {acc_adj, opnd_q} << 1;

        case (state_q)
            ST_IDLE: begin
                if (bus.Load) begin
                    if (64'(bus.Value) > MAX_VAL) begin
                        opnd_d = WIDTH'(MAX_VAL);
                        ovf_d  = 1'b1;
                    end else begin
                        opnd_d = bus.Value;
                        ovf_d  = 1'b0;
                    end
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_d  = pair_sh[BCD_W+WIDTH-1:WIDTH];
                opnd_d = pair_sh[WIDTH-1:0];
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    disp_d  = pair_sh[BCD_W+WIDTH-1:WIDTH];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end

        // Scan outputs are registered from next-state values so the digit,
        // its select and any new display contents appear on the same edge.
`ifdef LEADING_ZERO_BLANK_EN
        blank     = '0;
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead_zero = lead_zero & (disp_d[4*i +: 4] == 4'd0);
            blank[i]  = lead_zero;
        end
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx_d) begin
                sel_d[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                bcd_d = blank[i] ? 4'hF : disp_d[4*i +: 4];
`else
                bcd_d = disp_d[4*i +: 4];
`endif
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            bcd_q   <= 4'd0;
            sel_q   <= ~DIGITS'(1);
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Ovf      = ovf_q;
    assign bus.BCD      = bcd_q;
    assign bus.DigitSel = sel_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_driver
// Directed bench for bcd_scan_driver: one instance with SCAN_DIV=4 for the
// conversion/display checks and one with SCAN_DIV=1 for the scan sequence.
// Expected values are hand-computed constants; leading-zero-blank build
// (LEADING_ZERO_BLANK_EN) uses its own constants.
// ---------------------------------------------------------------------------
module tb_bcd_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bcd_scan_driver_if #(.WIDTH(14), .DIGITS(4)) bus4 ();
    bcd_scan_driver_if #(.WIDTH(14), .DIGITS(4)) bus1 ();

    bcd_scan_driver #(.WIDTH(14), .DIGITS(4), .SCAN_DIV(4)) dut4 (
        .CLK (clk),
        .RST (rst),
        .bus (bus4.slave)
    );

    bcd_scan_driver #(.WIDTH(14), .DIGITS(4), .SCAN_DIV(1)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (bus1.slave)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [15:0] EXP_5    = 16'hFFF5;
    localparam logic [15:0] EXP_7    = 16'hFFF7;
    localparam logic [15:0] EXP_ZERO = 16'hFFF0;
`else
    localparam logic [15:0] EXP_5    = 16'h0005;
    localparam logic [15:0] EXP_7    = 16'h0007;
    localparam logic [15:0] EXP_ZERO = 16'h0000;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Collect the four scanned digits by waiting for each digit select.
    task automatic read_disp(output logic [15:0] d);
        int         w;
        logic [3:0] want;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            want = ~(4'b0001 << i);
            w = 0;
            while (bus4.DigitSel !== want && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (w >= 40) chk("scan_slot", {28'd0, bus4.DigitSel}, {28'd0, want});
            d[i*4 +: 4] = bus4.BCD;
        end
    endtask

    task automatic conv(input string tag, input logic [13:0] v, input bit inject,
                        input logic [15:0] exp_disp, input bit exp_ovf);
        int          n;
        int          dn;
        logic [15:0] d;
        n  = 0;
        dn = 0;
        @(negedge clk);
        bus4.Value = v;
        bus4.Load  = 1'b1;
        @(negedge clk);
        bus4.Load  = 1'b0;
        while (bus4.Busy && n < 100) begin
            if (bus4.Done) dn++;
            if (inject && n == 2) begin
                bus4.Value = 14'd42;
                bus4.Load  = 1'b1;
            end else begin
                bus4.Load  = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        bus4.Load = 1'b0;
        chk({tag, "_busy_cycles"}, n, 14);
        chk({tag, "_done_high"}, {31'd0, bus4.Done}, 1);
        if (bus4.Done) dn++;
        chk({tag, "_ovf"}, {31'd0, bus4.Ovf}, {31'd0, exp_ovf});
        @(negedge clk);
        chk({tag, "_done_low"}, {31'd0, bus4.Done}, 0);
        if (bus4.Done) dn++;
        chk({tag, "_done_count"}, dn, 1);
        read_disp(d);
        chk({tag, "_disp"}, {16'd0, d}, {16'd0, exp_disp});
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  seq [5];
        int          w;
        int          dn;

        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011;
        seq[3] = 4'b0111; seq[4] = 4'b1110;

        bus4.Value = '0; bus4.Load = 1'b0;
        bus1.Value = '0; bus1.Load = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus4.Busy}, 0);
        chk("rst_done", {31'd0, bus4.Done}, 0);
        chk("rst_ovf",  {31'd0, bus4.Ovf}, 0);
        chk("rst_sel",  {28'd0, bus4.DigitSel}, 32'hE);
        chk("rst_bcd",  {28'd0, bus4.BCD}, 0);
        rst = 1'b0;

        conv("v1234",  14'd1234,  1'b0, 16'h1234, 1'b0);
        conv("v12000", 14'd12000, 1'b0, 16'h9999, 1'b1);
        conv("v5",     14'd5,     1'b0, EXP_5,    1'b0);
        conv("v5678",  14'd5678,  1'b1, 16'h5678, 1'b0);
        conv("v7",     14'd7,     1'b0, EXP_7,    1'b0);
        conv("v0",     14'd0,     1'b0, EXP_ZERO, 1'b0);
        conv("v9999",  14'd9999,  1'b0, 16'h9999, 1'b0);

        // Reset in the middle of an over-range conversion.
        @(negedge clk);
        bus4.Value = 14'd12000;
        bus4.Load  = 1'b1;
        @(negedge clk);
        bus4.Load  = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_pre", {31'd0, bus4.Busy}, 1);
        chk("mid_ovf_pre",  {31'd0, bus4.Ovf}, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, bus4.Busy}, 0);
        chk("mid_rst_done", {31'd0, bus4.Done}, 0);
        chk("mid_rst_ovf",  {31'd0, bus4.Ovf}, 0);
        chk("mid_rst_sel",  {28'd0, bus4.DigitSel}, 32'hE);
        chk("mid_rst_bcd",  {28'd0, bus4.BCD}, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus4.Done) dn++;
        end
        chk("mid_rst_no_done", dn, 0);
        read_disp(d);
        chk("mid_rst_disp", {16'd0, d}, {16'd0, EXP_ZERO});

        // SCAN_DIV=1: select advances every clock.
        w = 0;
        while (bus1.DigitSel !== 4'b1110 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("div1_start", {28'd0, bus1.DigitSel}, 32'hE);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            chk("div1_seq", {28'd0, bus1.DigitSel}, {28'd0, seq[k]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
- Sequential front end for the 7-segment display path.
- Accepts a binary value on a Load pulse and converts it to packed BCD iteratively (shift-and-add-3, one bit per clock).
- Holds the result in a display register and time-multiplexes the digits, presenting one 4-bit BCD digit plus an active-low digit select per scan slot.
- Sits directly upstream of the BCD-to-segment decoder: BCD output feeds the decoder's BCD input; DigitSel drives the display anodes.

Parameters:
- WIDTH, 14, width of binary input Value (14 bits covers 0..9999).
- DIGITS, 4, number of display digits/BCD nibbles.
- SCAN_DIV, 50000, clocks per scan slot; legal range >= 1.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- Value  input  WIDTH  binary value to display; sampled only on an accepted Load.
- Load  input  1  request to convert Value; accepted only when Busy=0.
- Busy  output  1  conversion in progress.
- Done  output  1  one-cycle pulse when the display register updates.
- Ovf  output  1  last accepted Value exceeded 10^DIGITS-1.
- BCD  output  4  BCD digit for the current scan slot, to the decoder.
- DigitSel  output  DIGITS  active-low one-hot digit enable; bit i selects digit i, where digit 0 is the least significant.

Behaviour:
- Reset (async, immediate):
  - display register = 0; scan index = 0; prescaler = 0; iteration counter = 0.
  - Busy = 0, Done = 0, Ovf = 0.
  - DigitSel = all ones except bit 0 = 0; BCD = 0.
  - RST during a conversion aborts it; no Done is issued.
- Load acceptance (edge E0 where Load=1 and Busy=0):
  - If Value > 10^DIGITS-1, the operand is clamped to 10^DIGITS-1 and Ovf is set to 1; otherwise Ovf is cleared.
  - Operand goes into the shift register, BCD accumulator = 0, counter = WIDTH, Busy = 1.
- Load while Busy=1 is ignored: no effect on the operand, Ovf or the counter.
- Iteration, one per edge while Busy=1:
  - For each nibble >= 5, add 3.
  - Shift the {accumulator, operand} pair left 1.
  - Decrement the counter.
- Completion: on the edge where the counter goes 1->0:
  - The final accumulator is written to the display register.
  - Busy -> 0 and Done -> 1 for exactly one cycle.
  - Done is therefore high in the cycle after edge E0+WIDTH; Busy is high for exactly WIDTH cycles.
  - A new Load is accepted in the same cycle Done is high.
- Display register changes only at completion. Scan output never shows a partial conversion.
- Scan timing:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the scan index increments modulo DIGITS (DIGITS-1 -> 0).
  - SCAN_DIV=1 advances the index every clock.
- Scan outputs:
  - BCD = display register nibble[index]; DigitSel = ~(1 << index).
  - Both are driven from registered state and change on the same edge as the index.
  - Scanning runs continuously, independent of Busy.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: any digit above the most significant nonzero digit outputs BCD = 4'hF, which the decoder maps to all segments off.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - The blank mask is computed from the display register and updates at completion with it.
- Undefined: all digits output their nibble, leading zeros included.
- The port list is identical in both builds.

Test Plan (WIDTH=14, DIGITS=4, SCAN_DIV=4 unless stated):
- Reset: assert RST mid-operation -> Busy=0, Done=0, Ovf=0, DigitSel=4'b1110, BCD=0 immediately, without a clock edge.
- Load Value=1234:
  - Busy is high for 14 cycles, then Done pulses once and the display register = 16'h1234.
  - Scanning with DigitSel=1110/1101/1011/0111 gives BCD 4/3/2/1.
- Load Value=12000 -> display register = 16'h9999 and Ovf=1. A following Load of 5 -> Ovf=0 and display register = 16'h0005.
- Load 5678, then Load=1 with Value=42 on the 3rd Busy cycle -> second Load ignored; result 16'h5678; exactly one Done.
- Scan wrap with SCAN_DIV=1 -> index cycles 0,1,2,3,0 on consecutive clocks; DigitSel follows 1110,1101,1011,0111,1110.
- Value=7 with LEADING_ZERO_BLANK_EN defined -> digits 3..1 give BCD=4'hF and digit 0 gives 7. Value=0 -> digit 0 gives 0. Macro undefined -> digits 3..1 give 0.
